// File: rtl/mem_port_ctrl_pkg.sv
// Shared types for the CPU-to-memory port controller: FSM states,
// load/store size classes and the base byte-lane masks.
package mem_port_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_e;

    // Same encodings as the rv32i load/store funct3 fields
    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BYTE_U = 3'b100;
    localparam logic [2:0] F3_HALF_U = 3'b101;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage

// File: rtl/mem_port_mask.sv
// Combinational lane-mask and misalignment decode from funct3 and the
// low two address bits. Unknown funct3 values are treated as word accesses.
module mem_port_mask
    import mem_port_types::*;
(
    input  logic [2:0] funct3_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] byte_enable_o,
    output logic       misaligned_o
);

    always_comb begin
        byte_enable_o = MASK_WORD;
        misaligned_o  = 1'b0;
        case (funct3_i)
            F3_BYTE, F3_BYTE_U: begin
                byte_enable_o = MASK_BYTE << addr_lo_i;
            end
            F3_HALF, F3_HALF_U: begin
                byte_enable_o = MASK_HALF << addr_lo_i;
                misaligned_o  = addr_lo_i[0];
            end
            default: begin
                misaligned_o = (addr_lo_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Single-request memory port controller between the multicycle CPU and the
// memory/cache port. Optional statistics counters under MEM_PORT_STATS_EN.
module mem_port_ctrl
    import mem_port_types::*;
#(
    parameter int unsigned STATS_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_funct3,
    output logic [31:0] cpu_rdata,
    output logic        cpu_resp,
    output logic        cpu_misaligned,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
`ifdef MEM_PORT_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] stat_reads,
    output logic [STATS_WIDTH-1:0] stat_writes,
    output logic [STATS_WIDTH-1:0] stat_stall_cycles
`endif
);

    state_e      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q,  mask_d;
    logic        write_q, write_d;
    logic [31:0] rdata_q, rdata_d;

    logic [3:0]  req_mask;
    logic        req_misaligned;

    mem_port_mask u_mask (
        .funct3_i      (cpu_funct3),
        .addr_lo_i     (cpu_address[1:0]),
        .byte_enable_o (req_mask),
        .misaligned_o  (req_misaligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        write_d = write_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_read || cpu_write) begin
                    addr_d  = {cpu_address[31:2], 2'b00};
                    wdata_d = cpu_wdata;
                    mask_d  = req_mask;
                    write_d = cpu_write;
                    state_d = req_misaligned ? FAULT : ISSUE;
                end
            end
            ISSUE: begin
                if (mem_resp) begin
                    if (!write_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from state so an async reset drops them at once
    assign mem_read        = (state_q == ISSUE) && !write_q;
    assign mem_write       = (state_q == ISSUE) &&  write_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;
    assign mem_byte_enable = mask_q;
    assign cpu_resp        = (state_q == DONE) || (state_q == FAULT);
    assign cpu_misaligned  = (state_q == FAULT);
    assign cpu_rdata       = rdata_q;

`ifdef MEM_PORT_STATS_EN
    logic [2:0] stat_inc;

    assign stat_inc[0] = (state_q == DONE)  && !write_q;
    assign stat_inc[1] = (state_q == DONE)  &&  write_q;
    assign stat_inc[2] = (state_q == ISSUE) && !mem_resp;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stat
            logic [STATS_WIDTH-1:0] cnt_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else if (stat_inc[gi] && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    endgenerate

    assign stat_reads        = g_stat[0].cnt_q;
    assign stat_writes       = g_stat[1].cnt_q;
    assign stat_stall_cycles = g_stat[2].cnt_q;
`else
    // Counters absent; STATS_WIDTH stays in the interface so builds swap freely.
    generate
        if (STATS_WIDTH == 0) begin : g_no_stats
        end
    endgenerate
`endif

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed self-checking bench for mem_port_ctrl; stats checks only when
// MEM_PORT_STATS_EN is defined.
module tb_mem_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_address, cpu_wdata;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_rdata;
    logic        cpu_resp, cpu_misaligned;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;
`ifdef MEM_PORT_STATS_EN
    logic [31:0] stat_reads, stat_writes, stat_stall_cycles;
`endif

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk = ~clk;

    mem_port_ctrl #(.STATS_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_read        (cpu_read),
        .cpu_write       (cpu_write),
        .cpu_address     (cpu_address),
        .cpu_wdata       (cpu_wdata),
        .cpu_funct3      (cpu_funct3),
        .cpu_rdata       (cpu_rdata),
        .cpu_resp        (cpu_resp),
        .cpu_misaligned  (cpu_misaligned),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
`ifdef MEM_PORT_STATS_EN
        ,
        .stat_reads        (stat_reads),
        .stat_writes       (stat_writes),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request, answers mem_resp after `waits` stall cycles, drops the
    // request on cpu_resp and scrambles the request inputs mid-transaction.
    task automatic run_txn(input string tag, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] f3, input int waits, input logic [31:0] rdat,
                           output int n_rd, output int n_wr, output int n_resp,
                           output logic mis, output logic [31:0] m_addr,
                           output logic [31:0] m_wd, output logic [3:0] m_be);
        int  issue_cycles = 0;
        bit  done = 0;
        n_rd = 0; n_wr = 0; n_resp = 0; mis = 1'b0;
        m_addr = '0; m_wd = '0; m_be = '0;
        cpu_read = rd; cpu_write = wr; cpu_address = a; cpu_wdata = wd; cpu_funct3 = f3;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if (mem_read || mem_write) begin
                if (mem_read)  n_rd++;
                if (mem_write) n_wr++;
                m_addr = mem_address; m_wd = mem_wdata; m_be = mem_byte_enable;
                mem_resp  = (issue_cycles == waits);
                mem_rdata = rdat;
                issue_cycles++;
                cpu_address = 32'hFFFF_FFFF; cpu_wdata = 32'h5555_5555; cpu_funct3 = 3'b000;
            end else begin
                mem_resp = 1'b0;
            end
            if (cpu_resp) begin
                n_resp++;
                mis = cpu_misaligned;
                cpu_read = 1'b0; cpu_write = 1'b0;
                done = 1;
            end
        end
        if (!done) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        tick();
        mem_resp = 1'b0;
        if (cpu_resp)  n_resp++;
        if (mem_read)  n_rd++;
        if (mem_write) n_wr++;
        $display("TXN %s rd=%0d wr=%0d resp=%0d mis=%0b addr=%08h be=%04b wdata=%08h rdata=%08h",
                 tag, n_rd, n_wr, n_resp, mis, m_addr, m_be, m_wd, cpu_rdata);
    endtask

    int          n_rd, n_wr, n_resp;
    logic        mis;
    logic [31:0] m_addr, m_wd;
    logic [3:0]  m_be;

    initial begin
        rst = 1'b0;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_wdata = '0; cpu_funct3 = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        #1;
        check_eq("rst_resp",  {31'd0, cpu_resp}, 32'd0);
        check_eq("rst_rd",    {31'd0, mem_read}, 32'd0);
        check_eq("rst_rdata", cpu_rdata, 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // lw 0x1004, three stall cycles
        run_txn("lw_1004", 1, 0, 32'h0000_1004, 32'h0, 3'b010, 3, 32'hDEAD_BEEF,
                n_rd, n_wr, n_resp, mis, m_addr, m_wd, m_be);
        check_eq("lw_rd_cycles", n_rd, 4);
        check_eq("lw_wr_cycles", n_wr, 0);
        check_eq("lw_resp",      n_resp, 1);
        check_eq("lw_mis",       {31'd0, mis}, 0);
        check_eq("lw_addr",      m_addr, 32'h0000_1004);
        check_eq("lw_be",        {28'd0, m_be}, 32'hF);
        check_eq("lw_rdata",     cpu_rdata, 32'hDEAD_BEEF);

        // sb 0x2003
        run_txn("sb_2003", 0, 1, 32'h0000_2003, 32'hAB00_0000, 3'b000, 1, 32'h0BAD_0BAD,
                n_rd, n_wr, n_resp, mis, m_addr, m_wd, m_be);
        check_eq("sb_wr_cycles", n_wr, 2);
        check_eq("sb_rd_cycles", n_rd, 0);
        check_eq("sb_resp",      n_resp, 1);
        check_eq("sb_addr",      m_addr, 32'h0000_2000);
        check_eq("sb_be",        {28'd0, m_be}, 32'h8);
        check_eq("sb_wdata",     m_wd, 32'hAB00_0000);
        check_eq("sb_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);

        // sh 0x3001: misaligned
        run_txn("sh_3001", 0, 1, 32'h0000_3001, 32'h0000_1234, 3'b001, 0, 32'h0,
                n_rd, n_wr, n_resp, mis, m_addr, m_wd, m_be);
        check_eq("sh_strobes", n_rd + n_wr, 0);
        check_eq("sh_resp",    n_resp, 1);
        check_eq("sh_mis",     {31'd0, mis}, 1);

        // read and write together: write wins
        run_txn("rw_0040", 1, 1, 32'h0000_0040, 32'hCAFE_F00D, 3'b010, 0, 32'h0,
                n_rd, n_wr, n_resp, mis, m_addr, m_wd, m_be);
        check_eq("rw_wr_cycles", n_wr, 1);
        check_eq("rw_rd_cycles", n_rd, 0);
        check_eq("rw_be",        {28'd0, m_be}, 32'hF);
        check_eq("rw_wdata",     m_wd, 32'hCAFE_F00D);

        // back-to-back loads, request held into the IDLE cycle after cpu_resp
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 32'h0000_0100; cpu_funct3 = 3'b010;
        tick();
        check_eq("b2b_rd1", {31'd0, mem_read}, 1);
        mem_resp = 1'b1; mem_rdata = 32'h1111_0001;
        tick();
        check_eq("b2b_resp1",  {31'd0, cpu_resp}, 1);
        check_eq("b2b_rdata1", cpu_rdata, 32'h1111_0001);
        mem_resp = 1'b0; cpu_address = 32'h0000_0104;
        tick();
        check_eq("b2b_idle_rd",   {31'd0, mem_read}, 0);
        check_eq("b2b_idle_resp", {31'd0, cpu_resp}, 0);
        tick();
        check_eq("b2b_rd2",   {31'd0, mem_read}, 1);
        check_eq("b2b_addr2", mem_address, 32'h0000_0104);
        cpu_read = 1'b0; mem_resp = 1'b1; mem_rdata = 32'h2222_0002;
        tick();
        check_eq("b2b_resp2",  {31'd0, cpu_resp}, 1);
        check_eq("b2b_rdata2", cpu_rdata, 32'h2222_0002);
        mem_resp = 1'b0;
        tick();
        check_eq("b2b_end_resp", {31'd0, cpu_resp}, 0);
        $display("TXN b2b_0100_0104 rdata=%08h", cpu_rdata);

        // reset mid-ISSUE, then a late mem_resp
        cpu_read = 1'b1; cpu_address = 32'h0000_0500; cpu_funct3 = 3'b010;
        tick(); tick(); tick();
        check_eq("rstmid_rd_before", {31'd0, mem_read}, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("rstmid_rd",    {31'd0, mem_read}, 0);
        check_eq("rstmid_addr",  mem_address, 32'd0);
        check_eq("rstmid_be",    {28'd0, mem_byte_enable}, 0);
        check_eq("rstmid_rdata", cpu_rdata, 32'd0);
`ifdef MEM_PORT_STATS_EN
        check_eq("rstmid_stat_rd",    stat_reads, 0);
        check_eq("rstmid_stat_stall", stat_stall_cycles, 0);
`endif
        cpu_read = 1'b0;
        #1 rst = 1'b1;
        mem_resp = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        check_eq("late_resp",  {31'd0, cpu_resp}, 0);
        check_eq("late_rd",    {31'd0, mem_read}, 0);
        mem_resp = 1'b0;
        tick();
        check_eq("late_resp2", {31'd0, cpu_resp}, 0);
        check_eq("late_rdata", cpu_rdata, 32'd0);
        $display("TXN reset_mid_issue rdata=%08h", cpu_rdata);

        run_txn("lw_0800", 1, 0, 32'h0000_0800, 32'h0, 3'b010, 2, 32'h0A0B_0C0D,
                n_rd, n_wr, n_resp, mis, m_addr, m_wd, m_be);
        check_eq("post_rst_resp",  n_resp, 1);
        check_eq("post_rst_rdata", cpu_rdata, 32'h0A0B_0C0D);

        run_txn("lhu_0602", 1, 0, 32'h0000_0602, 32'h0, 3'b101, 0, 32'h1234_5678,
                n_rd, n_wr, n_resp, mis, m_addr, m_wd, m_be);
        check_eq("lhu_be",   {28'd0, m_be}, 32'hC);
        check_eq("lhu_addr", m_addr, 32'h0000_0600);
        check_eq("lhu_mis",  {31'd0, mis}, 0);

        run_txn("lw_0002", 1, 0, 32'h0000_0002, 32'h0, 3'b010, 0, 32'h0,
                n_rd, n_wr, n_resp, mis, m_addr, m_wd, m_be);
        check_eq("lw2_mis",     {31'd0, mis}, 1);
        check_eq("lw2_strobes", n_rd + n_wr, 0);

`ifdef MEM_PORT_STATS_EN
        check_eq("stat_reads",  stat_reads, 2);
        check_eq("stat_writes", stat_writes, 0);
        check_eq("stat_stall",  stat_stall_cycles, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
